// File: rtl/sentinel_seq_lock.sv
// Multi-entry key-sequence lock with failure counting and timed lockout.
// Optional macro SENTINEL_AUTO_RELOCK_EN adds an UNLOCKED dwell timeout.
module sentinel_seq_lock #(
    parameter int KEY_W = 8,
    parameter int KEY_LEN = 4,
    parameter logic [KEY_W*KEY_LEN-1:0] KEY_SEQ = 32'h19C35AB6,
    parameter int MAX_FAILS = 3,
    parameter int LOCKOUT_CYCLES = 1024
`ifdef SENTINEL_AUTO_RELOCK_EN
    ,
    parameter int RELOCK_CYCLES = 4096
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [KEY_W-1:0]               key_in,
    input  logic                           key_valid,
    input  logic                           relock,
    output logic                           unlocked,
    output logic                           lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
    output logic [7:0]                     seg_out,
    output logic [7:0]                     glow_out
);

    localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES);
`ifdef SENTINEL_AUTO_RELOCK_EN
    localparam int DW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
`endif

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_LOCKOUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mis_q, mis_d;
    logic [FW-1:0]    fail_q, fail_d;
    logic [TW-1:0]    timer_q, timer_d;
`ifdef SENTINEL_AUTO_RELOCK_EN
    logic [DW-1:0]    dwell_q, dwell_d;
`endif

    logic [KEY_W-1:0] exp_key;
    logic             miss;
    logic             last;
    logic             blink;

    always_comb begin
        exp_key = KEY_SEQ[KEY_W-1:0];
        for (int i = 1; i < KEY_LEN; i++) begin
            if (idx_q == IDX_W'(i)) exp_key = KEY_SEQ[i*KEY_W +: KEY_W];
        end
    end

    // Mismatch is sticky so every attempt consumes all entries regardless.
    assign miss = mis_q | (key_in != exp_key);
    assign last = (idx_q == IDX_W'(KEY_LEN - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        fail_d  = fail_q;
        timer_d = timer_q;
`ifdef SENTINEL_AUTO_RELOCK_EN
        dwell_d = dwell_q;
`endif
        unique case (state_q)
            S_LOCKED: begin
                if (relock) begin
                    idx_d = '0;
                    mis_d = 1'b0;
                end else if (key_valid) begin
                    if (last) begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (!miss) begin
                            state_d = S_UNLOCKED;
                            fail_d  = '0;
`ifdef SENTINEL_AUTO_RELOCK_EN
                            dwell_d = DW'(RELOCK_CYCLES - 1);
`endif
                        end else if (fail_q == FW'(MAX_FAILS - 1)) begin
                            state_d = S_LOCKOUT;
                            fail_d  = FW'(MAX_FAILS);
                            timer_d = TW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            fail_d = fail_q + 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        mis_d = miss;
                    end
                end
            end
            S_UNLOCKED: begin
                if (relock) begin
                    state_d = S_LOCKED;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                end
`ifdef SENTINEL_AUTO_RELOCK_EN
                else if (dwell_q == '0) begin
                    state_d = S_LOCKED;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
`endif
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_LOCKED;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOCKED;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            fail_q  <= '0;
            timer_q <= '0;
`ifdef SENTINEL_AUTO_RELOCK_EN
            dwell_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
`ifdef SENTINEL_AUTO_RELOCK_EN
            dwell_q <= dwell_d;
`endif
        end
    end

    generate
        if (TW > 4) begin : g_blink
            assign blink = timer_q[4];
        end else begin : g_noblink
            assign blink = 1'b0;
        end
    endgenerate

    assign unlocked = (state_q == S_UNLOCKED);
    assign lockout  = (state_q == S_LOCKOUT);
    assign fail_cnt = fail_q;

    always_comb begin
        seg_out  = 8'hFF;
        glow_out = 8'h00;
        if (ena) begin
            unique case (state_q)
                S_UNLOCKED: begin
                    seg_out  = 8'hC1;
                    glow_out = 8'hFF;
                end
                S_LOCKOUT: begin
                    seg_out  = 8'hBF;
                    glow_out = {8{blink}};
                end
                default: seg_out = 8'hC7;
            endcase
        end
    end

endmodule
